fieldbuf_arb: RTL and testbench

FIELDBUF_ARB -- requirements
Module: fieldbuf_arb

---
 rtl/fieldbuf_pkg.sv | 19 +
 rtl/fieldbuf_rr2.sv | 23 ++
 rtl/fieldbuf_arb.sv | 143 ++++++++++++++
 tb/tb_fieldbuf_arb.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fieldbuf_pkg.sv
// Shared width constants, FSM state encoding and last-served encoding for the
// field buffer arbiter.
package fieldbuf_pkg;

  localparam int BUFP_W   = 3;
  localparam int FIELDP_W = 5;
  localparam int BUFFER_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_C = 2'd1,
    SERVE_H = 2'd2
  } arb_state_e;

  // Encoding of the last-served pointer
  localparam logic LAST_C = 1'b0;
  localparam logic LAST_H = 1'b1;

endpackage

// File: rtl/fieldbuf_rr2.sv
// Two-way round-robin picker: a sole requester wins, a tie goes to the side
// that was not served last. win[0] = core, win[1] = host.
module fieldbuf_rr2
  import fieldbuf_pkg::*;
(
  input  logic       c_req,
  input  logic       h_req,
  input  logic       last_h,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    if (c_req && h_req) begin
      win = (last_h == LAST_H) ? 2'b01 : 2'b10;
    end else if (c_req) begin
      win = 2'b01;
    end else if (h_req) begin
      win = 2'b10;
    end
  end

endmodule

// File: rtl/fieldbuf_arb.sv
// Core/host arbiter for a single-port field buffer memory.
// Optional host exclusive lock: define FIELDBUF_ARB_HOST_LOCK_EN.
module fieldbuf_arb
  import fieldbuf_pkg::*;
#(
  parameter int BUFP_WIDTH   = BUFP_W,
  parameter int FIELDP_WIDTH = FIELDP_W,
  parameter int BUFFER_WIDTH = BUFFER_W
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               c_req,
  input  logic                               c_we,
  input  logic [BUFP_WIDTH-1:0]              c_bufp,
  input  logic [FIELDP_WIDTH-1:0]            c_fieldp,
  input  logic [BUFFER_WIDTH-1:0]            c_wdata,
  output logic                               c_gnt,
  output logic                               c_rvalid,
  output logic [BUFFER_WIDTH-1:0]            c_rdata,
  input  logic                               h_req,
  input  logic                               h_we,
  input  logic [BUFP_WIDTH-1:0]              h_bufp,
  input  logic [FIELDP_WIDTH-1:0]            h_fieldp,
  input  logic [BUFFER_WIDTH-1:0]            h_wdata,
  input  logic                               h_lock,
  output logic                               h_gnt,
  output logic                               h_rvalid,
  output logic [BUFFER_WIDTH-1:0]            h_rdata,
  output logic                               mem_en,
  output logic                               mem_we,
  output logic [BUFP_WIDTH+FIELDP_WIDTH-1:0] mem_adr,
  output logic [BUFFER_WIDTH-1:0]            mem_wdata,
  input  logic [BUFFER_WIDTH-1:0]            mem_rdata,
  output logic [1:0]                         dbg_state
);

  localparam int ADR_W = BUFP_WIDTH + FIELDP_WIDTH;

  // Handshake: a requester holds req and its attributes until it samples gnt
  // high; the request is latched in IDLE and served in the following cycle, a
  // req still high after gnt is a new request, and req is not looked at while
  // serving. A read returns rvalid/rdata exactly one cycle after gnt.

  arb_state_e               state_q, state_d;
  logic                     op_we_q;
  logic [ADR_W-1:0]         op_adr_q;
  logic [BUFFER_WIDTH-1:0]  op_wdata_q;
  logic                     last_h_q;
  logic                     rv_c_q, rv_h_q;
  logic                     c_elig;
  logic [1:0]               win;

`ifdef FIELDBUF_ARB_HOST_LOCK_EN
  logic lock_q;

  // The IDLE cycle that sees h_lock low releases the core in that same cycle
  assign c_elig = c_req & ~(lock_q & h_lock);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= 1'b0;
    end else if (state_q == IDLE) begin
      if (!h_lock) begin
        lock_q <= 1'b0;
      end else if (win[1]) begin
        lock_q <= 1'b1;
      end
    end
  end
`else
  logic unused_h_lock;

  assign unused_h_lock = h_lock;
  assign c_elig        = c_req;
`endif

  fieldbuf_rr2 u_rr2 (
    .c_req  (c_elig),
    .h_req  (h_req),
    .last_h (last_h_q),
    .win    (win)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (win[0]) begin
          state_d = SERVE_C;
        end else if (win[1]) begin
          state_d = SERVE_H;
        end
      end
      SERVE_C: state_d = IDLE;
      SERVE_H: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_we_q    <= 1'b0;
      op_adr_q   <= '0;
      op_wdata_q <= '0;
      last_h_q   <= LAST_H;
      rv_c_q     <= 1'b0;
      rv_h_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      rv_c_q  <= (state_q == SERVE_C) && !op_we_q;
      rv_h_q  <= (state_q == SERVE_H) && !op_we_q;
      if (state_q == IDLE) begin
        if (win[0]) begin
          op_we_q    <= c_we;
          op_adr_q   <= {c_bufp, c_fieldp};
          op_wdata_q <= c_wdata;
          last_h_q   <= LAST_C;
        end else if (win[1]) begin
          op_we_q    <= h_we;
          op_adr_q   <= {h_bufp, h_fieldp};
          op_wdata_q <= h_wdata;
          last_h_q   <= LAST_H;
        end
      end
    end
  end

  assign c_gnt     = (state_q == SERVE_C);
  assign h_gnt     = (state_q == SERVE_H);
  assign mem_en    = c_gnt | h_gnt;
  assign mem_we    = mem_en & op_we_q;
  assign mem_adr   = op_adr_q;
  assign mem_wdata = op_wdata_q;

  // Read data is forced to zero outside its valid cycle
  assign c_rvalid  = rv_c_q;
  assign h_rvalid  = rv_h_q;
  assign c_rdata   = rv_c_q ? mem_rdata : '0;
  assign h_rdata   = rv_h_q ? mem_rdata : '0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fieldbuf_arb.sv
// Self-checking bench for fieldbuf_arb: directed scenarios plus randomized
// core/host traffic checked against a transaction-level arbitration model.
module tb_fieldbuf_arb;
  import fieldbuf_pkg::*;

  localparam int BW = BUFP_W;
  localparam int FW = FIELDP_W;
  localparam int DW = BUFFER_W;
  localparam int AW = BW + FW;
  localparam int OPW = 1 + AW + DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          c_req, c_we, h_req, h_we, h_lock;
  logic [BW-1:0] c_bufp, h_bufp;
  logic [FW-1:0] c_fieldp, h_fieldp;
  logic [DW-1:0] c_wdata, h_wdata, c_rdata, h_rdata, mem_rdata, mem_wdata;
  logic          c_gnt, c_rvalid, h_gnt, h_rvalid, mem_en, mem_we;
  logic [AW-1:0] mem_adr;
  logic [1:0]    dbg_state;
  logic [39:0]   outs;

  int checks = 0;
  int errors = 0;

  logic [OPW-1:0] exp_c_q[$];
  logic [OPW-1:0] exp_h_q[$];
  logic           c_done, h_done;

  always #5 clk = ~clk;

  assign outs = {c_gnt, c_rvalid, c_rdata, h_gnt, h_rvalid, h_rdata,
                 mem_en, mem_we, mem_adr, mem_wdata, dbg_state};

  fieldbuf_arb #(.BUFP_WIDTH(BW), .FIELDP_WIDTH(FW), .BUFFER_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_bufp(c_bufp), .c_fieldp(c_fieldp),
    .c_wdata(c_wdata), .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .h_req(h_req), .h_we(h_we), .h_bufp(h_bufp), .h_fieldp(h_fieldp),
    .h_wdata(h_wdata), .h_lock(h_lock), .h_gnt(h_gnt), .h_rvalid(h_rvalid),
    .h_rdata(h_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    c_req = 0; c_we = 0; c_bufp = '0; c_fieldp = '0; c_wdata = '0;
    h_req = 0; h_we = 0; h_bufp = '0; h_fieldp = '0; h_wdata = '0;
    h_lock = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    mem_rdata = 8'hFF;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (outs !== 40'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h required 0", outs);
    end
    @(negedge clk);
    rst_n = 1;
    tick();
    checks++;
    if ({c_gnt, h_gnt, mem_en, c_rvalid, h_rvalid} !== 5'b0) begin
      errors++;
      $display("FAIL idle_after_reset got %b required 00000",
               {c_gnt, h_gnt, mem_en, c_rvalid, h_rvalid});
    end
  endtask

  task automatic test_core_read();
    do_reset();
    c_req = 1; c_we = 0; c_bufp = 3'd2; c_fieldp = 5'd5;
    tick();
    checks++;
    if ({c_gnt, h_gnt, mem_en, mem_we, mem_adr} !== {4'b1010, 8'h45}) begin
      errors++;
      $display("FAIL core_read_serve got gnt=%b%b en=%b we=%b adr=%h required 10 1 0 45",
               c_gnt, h_gnt, mem_en, mem_we, mem_adr);
    end
    c_req = 0;
    mem_rdata = 8'hA5;
    tick();
    checks++;
    if ({c_rvalid, h_rvalid, c_rdata, c_gnt} !== {2'b10, 8'hA5, 1'b0}) begin
      errors++;
      $display("FAIL core_read_data got rvalid=%b%b rdata=%h gnt=%b required 10 a5 0",
               c_rvalid, h_rvalid, c_rdata, c_gnt);
    end
    tick();
    checks++;
    if (c_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL core_read_once got c_rvalid=%b required 0", c_rvalid);
    end
  endtask

  task automatic test_host_write();
    do_reset();
    h_req = 1; h_we = 1; h_bufp = 3'd7; h_fieldp = 5'd31; h_wdata = 8'h3C;
    tick();
    checks++;
    if ({h_gnt, c_gnt, mem_en, mem_we, mem_adr, mem_wdata} !== {4'b1011, 8'hFF, 8'h3C}) begin
      errors++;
      $display("FAIL host_write_serve got gnt=%b%b en=%b we=%b adr=%h wdata=%h required 10 1 1 ff 3c",
               h_gnt, c_gnt, mem_en, mem_we, mem_adr, mem_wdata);
    end
    h_req = 0;
    tick();
    checks++;
    if ({c_rvalid, h_rvalid, mem_en, mem_we, mem_adr, mem_wdata} !== {4'b0000, 8'hFF, 8'h3C}) begin
      errors++;
      $display("FAIL host_write_after got rvalid=%b%b en=%b we=%b adr=%h wdata=%h required 00 0 0 ff 3c",
               c_rvalid, h_rvalid, mem_en, mem_we, mem_adr, mem_wdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g;
    do_reset();
    c_req = 1; c_we = 1; c_bufp = 3'd1; c_fieldp = 5'd1; c_wdata = 8'h11;
    h_req = 1; h_we = 1; h_bufp = 3'd6; h_fieldp = 5'd6; h_wdata = 8'h66;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_g = (i % 4 == 1) ? 2'b01 : (i % 4 == 3) ? 2'b10 : 2'b00;
      checks++;
      if ({h_gnt, c_gnt} !== exp_g) begin
        errors++;
        $display("FAIL alternate cycle %0d got h,c gnt=%b required %b", i, {h_gnt, c_gnt}, exp_g);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_inflight();
    do_reset();
    c_req = 1; c_we = 0; c_bufp = 3'd3; c_fieldp = 5'd9;
    mem_rdata = 8'hA5;
    tick();
    checks++;
    if (c_gnt !== 1'b1) begin
      errors++;
      $display("FAIL inflight_grant got c_gnt=%b required 1", c_gnt);
    end
    c_req = 0;
    #2 rst_n = 0;
    #1;
    checks++;
    if (outs !== 40'd0) begin
      errors++;
      $display("FAIL inflight_reset_outputs got %h required 0", outs);
    end
    repeat (2) begin
      tick();
      checks++;
      if (outs !== 40'd0) begin
        errors++;
        $display("FAIL inflight_held_reset got %h required 0", outs);
      end
    end
    @(negedge clk);
    rst_n = 1;
    h_req = 1; h_we = 0; h_bufp = 3'd1; h_fieldp = 5'd2;
    tick();
    checks++;
    if ({c_gnt, h_gnt, c_rvalid} !== 3'b010) begin
      errors++;
      $display("FAIL inflight_first_grant got c_gnt,h_gnt,c_rvalid=%b required 010",
               {c_gnt, h_gnt, c_rvalid});
    end
    h_req = 0;
    tick();
    checks++;
    if ({c_rvalid, h_rvalid, h_rdata} !== {2'b01, 8'hA5}) begin
      errors++;
      $display("FAIL inflight_host_read got rvalid=%b%b h_rdata=%h required 01 a5",
               c_rvalid, h_rvalid, h_rdata);
    end
  endtask

  task automatic test_lock();
    int exp_tab[9];
    logic [1:0] exp_g;
`ifdef FIELDBUF_ARB_HOST_LOCK_EN
    exp_tab = '{2, 0, 2, 0, 2, 0, 1, 0, 2};
`else
    exp_tab = '{2, 0, 1, 0, 2, 0, 1, 0, 2};
`endif
    do_reset();
    h_req = 1; h_we = 1; h_lock = 1; h_bufp = 3'd4; h_fieldp = 5'd4; h_wdata = 8'h44;
    for (int i = 1; i <= 9; i++) begin
      tick();
      exp_g = 2'(exp_tab[i-1]);
      checks++;
      if ({h_gnt, c_gnt} !== exp_g) begin
        errors++;
        $display("FAIL lock cycle %0d got h,c gnt=%b required %b", i, {h_gnt, c_gnt}, exp_g);
      end
      if (i == 1) begin
        c_req = 1; c_we = 1; c_bufp = 3'd2; c_fieldp = 5'd2; c_wdata = 8'h22;
      end
      if (i == 6) h_lock = 0;
    end
    idle_inputs();
    tick();
  endtask

  task automatic drive_c(input int n);
    int gap, wc;
    tick();
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        c_req = 0;
        repeat (gap) tick();
      end
      c_we = 1'($urandom); c_bufp = BW'($urandom); c_fieldp = FW'($urandom);
      c_wdata = DW'($urandom);
      c_req = 1;
      exp_c_q.push_back({c_we, c_bufp, c_fieldp, c_wdata});
      wc = 0;
      do begin
        tick();
        wc++;
      end while (!c_gnt && wc < 20);
      checks++;
      if (!c_gnt) begin
        errors++;
        $display("FAIL core_grant_timeout op %0d got no gnt required gnt within 20 cycles", k);
      end
      tick();
    end
    c_req = 0;
    c_done = 1;
  endtask

  task automatic drive_h(input int n);
    int gap, wc;
    tick();
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        h_req = 0;
        repeat (gap) tick();
      end
      h_we = 1'($urandom); h_bufp = BW'($urandom); h_fieldp = FW'($urandom);
      h_wdata = DW'($urandom);
      h_req = 1;
      exp_h_q.push_back({h_we, h_bufp, h_fieldp, h_wdata});
      wc = 0;
      do begin
        tick();
        wc++;
      end while (!h_gnt && wc < 20);
      checks++;
      if (!h_gnt) begin
        errors++;
        $display("FAIL host_grant_timeout op %0d got no gnt required gnt within 20 cycles", k);
      end
      tick();
    end
    h_req = 0;
    h_done = 1;
  endtask

  // Reference model: grant order from the round-robin rules, one access per two
  // cycles, read data returned one cycle after its grant to the granted side.
  task automatic monitor();
    logic prev_c = 0, prev_h = 0, prev_g = 0, last_h = 1, rv_c = 0, rv_h = 0;
    logic rd_grant;
    logic [DW-1:0] rd_c = '0, rd_h = '0;
    logic [OPW-1:0] exp_op, last_op = '0;
    logic [1:0] exp_w;
    int drain = 0;
    while (drain < 4) begin
      @(negedge clk);
      if (c_done && h_done) drain++;
      checks++;
      if ((c_gnt && h_gnt) || (c_rvalid && h_rvalid)) begin
        errors++;
        $display("FAIL exclusive got gnt=%b%b rvalid=%b%b required at most one high",
                 c_gnt, h_gnt, c_rvalid, h_rvalid);
      end
      checks++;
      if (mem_en !== (c_gnt | h_gnt) || (!mem_en && mem_we !== 1'b0)) begin
        errors++;
        $display("FAIL strobes got en=%b we=%b gnt=%b%b required en=gnt and we low when idle",
                 mem_en, mem_we, c_gnt, h_gnt);
      end
      checks++;
      if ({c_rvalid, h_rvalid} !== {rv_c, rv_h}) begin
        errors++;
        $display("FAIL rvalid got %b%b required %b%b", c_rvalid, h_rvalid, rv_c, rv_h);
      end
      if (rv_c) begin
        checks++;
        if (c_rdata !== rd_c) begin
          errors++;
          $display("FAIL c_rdata got %h required %h", c_rdata, rd_c);
        end
      end
      if (rv_h) begin
        checks++;
        if (h_rdata !== rd_h) begin
          errors++;
          $display("FAIL h_rdata got %h required %h", h_rdata, rd_h);
        end
      end
      rv_c = 0;
      rv_h = 0;
      if (!mem_en) begin
        checks++;
        if ({mem_adr, mem_wdata} !== last_op[AW+DW-1:0]) begin
          errors++;
          $display("FAIL bus_hold got adr=%h wdata=%h required %h", mem_adr, mem_wdata,
                   last_op[AW+DW-1:0]);
        end
      end
      if (prev_g) exp_w = 2'b00;
      else if (prev_c && (!prev_h || last_h)) exp_w = 2'b01;
      else if (prev_h) exp_w = 2'b10;
      else exp_w = 2'b00;
      checks++;
      if ({h_gnt, c_gnt} !== exp_w) begin
        errors++;
        $display("FAIL arbitration got h,c gnt=%b required %b (req was c=%b h=%b)",
                 {h_gnt, c_gnt}, exp_w, prev_c, prev_h);
      end
      rd_grant = 0;
      if (exp_w != 2'b00) begin
        exp_op = '0;
        checks++;
        if ((exp_w[0] && exp_c_q.size() == 0) || (exp_w[1] && exp_h_q.size() == 0)) begin
          errors++;
          $display("FAIL op_queue got grant with no pending op required a queued request");
        end else begin
          exp_op = exp_w[0] ? exp_c_q.pop_front() : exp_h_q.pop_front();
          if ({mem_we, mem_adr, mem_wdata} !== exp_op) begin
            errors++;
            $display("FAIL mem_op got we=%b adr=%h wdata=%h required %h",
                     mem_we, mem_adr, mem_wdata, exp_op);
          end
        end
        last_op = exp_op;
        last_h = exp_w[1];
        if (!exp_op[OPW-1]) begin
          rd_grant = 1;
          mem_rdata = DW'($urandom);
          if (exp_w[0]) begin rv_c = 1; rd_c = mem_rdata; end
          else begin rv_h = 1; rd_h = mem_rdata; end
        end
      end
      if (!rd_grant) mem_rdata = DW'($urandom);
      prev_c = c_req;
      prev_h = h_req;
      prev_g = (exp_w != 2'b00);
    end
    checks++;
    if (exp_c_q.size() != 0 || exp_h_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_ops got c=%0d h=%0d required 0 0", exp_c_q.size(), exp_h_q.size());
    end
  endtask

  task automatic test_random();
    do_reset();
    c_done = 0;
    h_done = 0;
    exp_c_q.delete();
    exp_h_q.delete();
    fork
      drive_c(40);
      drive_h(40);
      monitor();
    join
  endtask

  initial begin
    idle_inputs();
    mem_rdata = '0;
    c_done = 0;
    h_done = 0;
    test_reset();
    test_core_read();
    test_host_write();
    test_back_to_back();
    test_reset_inflight();
    test_lock();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion required finish before 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
